// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl_pkg
// Brief   : Shared FSM state encoding and defaults for the SRAM controller.
//           Byte-lane helper exists only with SRAM_CTRL_BYTE_LANE_EN defined.
// Rev     : 1.0  initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam int unsigned SRAM_WAIT_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_e;

`ifdef SRAM_CTRL_BYTE_LANE_EN
    // Disabled lanes read back as zero.
    function automatic logic [15:0] lane_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction
`endif

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/tristate16.sv
`default_nettype none
// ============================================================================
// Module  : tristate16
// Brief   : 16-bit bidirectional pad driver for the SRAM data bus.
// Rev     : 1.0  initial release
// ============================================================================
module tristate16 (
    input  logic [15:0] d,
    input  logic        oe,
    inout  wire  [15:0] bus,
    output logic [15:0] q
);

    assign bus = oe ? d : 16'hzzzz;
    assign q   = bus;

endmodule : tristate16
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl
// Brief   : Single-access asynchronous SRAM controller (SETUP/ACCESS/HOLD/DONE).
//           Optional byte lanes: define SRAM_CTRL_BYTE_LANE_EN.
// Rev     : 1.0  initial release
// ============================================================================
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = SRAM_WAIT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
`ifdef SRAM_CTRL_BYTE_LANE_EN
    input  logic [1:0]  be,
`endif
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        CE,
    output logic        OE,
    output logic        WE,
    output logic        UB,
    output logic        LB,
    output logic [17:0] ADDR,
    inout  wire  [15:0] Data
);

    localparam logic [3:0] c_WAIT_LOAD = WAIT_CYCLES[3:0];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [15:0] addr_q,  addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rw_q,    rw_d;
`ifdef SRAM_CTRL_BYTE_LANE_EN
    logic [1:0]  be_q,    be_d;
`endif

    logic [15:0] w_data_in;
    logic [15:0] w_capture;
    logic        w_data_oe;
    logic        w_active;
    logic        w_in_access;

    tristate16 u_data_pad (
        .d   (wdata_q),
        .oe  (w_data_oe),
        .bus (Data),
        .q   (w_data_in)
    );

`ifdef SRAM_CTRL_BYTE_LANE_EN
    assign w_capture = w_data_in & lane_mask(be_q);
`else
    assign w_capture = w_data_in;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
`ifdef SRAM_CTRL_BYTE_LANE_EN
        be_d    = be_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    addr_d  = addr;
                    wdata_d = wdata;
                    rw_d    = rw;
`ifdef SRAM_CTRL_BYTE_LANE_EN
                    be_d    = be;
`endif
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = c_WAIT_LOAD;
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                // Last wait cycle: sample the bus on the edge that leaves ACCESS.
                if (cnt_q == 4'd1) begin
                    state_d = HOLD;
                    if (!rw_q) begin
                        rdata_d = w_capture;
                    end
                end
            end
            HOLD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            rw_q    <= 1'b0;
`ifdef SRAM_CTRL_BYTE_LANE_EN
            be_q    <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
`ifdef SRAM_CTRL_BYTE_LANE_EN
            be_q    <= be_d;
`endif
        end
    end

    // Strobes decode straight from registered state so reset clears them at once.
    assign w_active    = (state_q == SETUP) || (state_q == ACCESS) || (state_q == HOLD);
    assign w_in_access = (state_q == ACCESS);
    assign w_data_oe   = rw_q && ((state_q == ACCESS) || (state_q == HOLD));

    assign CE    = ~w_active;
    assign OE    = ~(w_in_access && !rw_q);
    assign WE    = ~(w_in_access && rw_q);
`ifdef SRAM_CTRL_BYTE_LANE_EN
    assign UB    = w_active ? ~be_q[1] : 1'b1;
    assign LB    = w_active ? ~be_q[0] : 1'b1;
`else
    assign UB    = ~w_active;
    assign LB    = ~w_active;
`endif
    assign ADDR  = {2'b00, addr_q};
    assign rdata = rdata_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule : sram_ctrl
`default_nettype wire

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of ACCESS-state cycles; legal range 1..15.
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  access request from fetch/execute; sampled only in IDLE.
REQ-005 rw  input  1  1 = write, 0 = read; latched with req.
REQ-006 addr  input  16  word address (MAR); latched with req.
REQ-007 wdata  input  16  write data (MDR); latched with req.
REQ-008 rdata  output  16  registered read data.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 CE, OE, WE, UB, LB  output  1 each  active-low SRAM strobes.
REQ-012 ADDR  output  18  SRAM address.
REQ-013 Data  inout  16  SRAM data bus.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, ACCESS, HOLD and DONE.
REQ-015 In IDLE with req=1 at edge N, addr/rw/wdata SHALL be latched and the state SHALL be SETUP in cycle N+1.
REQ-016 SETUP SHALL last 1 cycle with CE=0, ADDR={2'b00, latched addr}, OE=1, WE=1.
REQ-017 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded in SETUP.
REQ-018 In a read ACCESS: CE=0, OE=0, WE=1, Data tri-stated; rdata SHALL capture Data at the edge ending the last ACCESS cycle.
REQ-019 In a write ACCESS: CE=0, OE=1, WE=0, and Data SHALL be driven with latched wdata.
REQ-020 HOLD SHALL last 1 cycle with WE=1, OE=1, CE=0 and ADDR held; for a write, Data SHALL remain driven through HOLD.
REQ-021 DONE SHALL last 1 cycle with done=1 and all strobes deasserted, then return to IDLE.
REQ-022 Latency: done SHALL be high in cycle N+WAIT_CYCLES+3, where N is the request edge.
REQ-023 req asserted in any non-IDLE state SHALL be ignored, with no queueing.
REQ-024 req sampled in the DONE cycle SHALL be ignored; the earliest accept edge is the first IDLE cycle.
REQ-025 Data SHALL be driven only in write ACCESS and write HOLD; it SHALL be high-impedance at all other times.
REQ-026 In IDLE: CE=OE=WE=UB=LB=1, ADDR holds the last value, and rdata holds its value.
REQ-027 A write SHALL never alter rdata.

Reset
REQ-028 Reset=0 SHALL immediately force IDLE, CE=OE=WE=UB=LB=1, Data high-Z, done=0, busy=0, rdata=16'h0000, ADDR=18'h00000 and counter=0.
REQ-029 Reset asserted mid-access SHALL abort the access with no done pulse.
REQ-030 On Reset release, the first accept SHALL be the first rising edge with Reset=1 and req=1.

Configuration
REQ-031 When SRAM_CTRL_BYTE_LANE_EN is defined, the design SHALL add input be[1:0], latched with req.
REQ-032 With the macro defined, UB=~be[1] and LB=~be[0] during SETUP, ACCESS and HOLD.
REQ-033 With the macro defined, a read with a disabled lane SHALL return 8'h00 in that byte of rdata.
REQ-034 When SRAM_CTRL_BYTE_LANE_EN is undefined, be SHALL NOT exist, UB=LB=0 during SETUP, ACCESS and HOLD, and all 16 bits SHALL be captured.

Structure
REQ-035 Package sram_ctrl_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS, HOLD, DONE) and the constant SRAM_WAIT_DEFAULT=2.
REQ-036 A single sub-module, tristate16, SHALL implement the Data bus driver (input d, input oe, inout bus, output q).

Verification
REQ-037 Read test: WAIT_CYCLES=2, model word 0x0010=16'hBEEF, req=1 rw=0 addr=16'h0010 at edge 5 -> OE=0 cycles 7-8, done=1 cycle 10, rdata=16'hBEEF.
REQ-038 Write test: addr=16'h0020, wdata=16'h1234, rw=1 -> WE=0 exactly 2 cycles, Data driven through HOLD, model[0x20]=16'h1234, rdata unchanged.
REQ-039 Busy-ignore test: second req (addr=16'h0030) held high during busy -> exactly one done, ADDR never equals 0x0030 during the first access, next accept in the first IDLE cycle.
REQ-040 Mid-access reset: Reset=0 during ACCESS -> same cycle CE=OE=WE=1, Data=Z, rdata=0, no done pulse.
REQ-041 WAIT_CYCLES=15 read -> done at N+18 and counter does not wrap.
REQ-042 Byte-lane read (with SRAM_CTRL_BYTE_LANE_EN): be=2'b01 on word 16'hBEEF -> UB=1, LB=0, rdata=16'h00EF.
